sgd_wr_host_arbiter: RTL and testbench

Two-port, packet-granular arbiter that shares the single host-memory write channel between two write requesters. Port 0 is the model (x) writeback engine; port 1 is the auxiliary writeback, e.g. loss/statistics. The channel has a command (start/addr/length) and a 512-bit data stream with almost_full back-pressure. Each requester sees a private copy of the channel. The arbiter grants one whole packet at a time with round-robin priority, forwards the command, counts data beats, and releases the grant after the last beat.

---
 rtl/sgd_wr_host_arbiter_if.sv | 17 +
 rtl/sgd_wr_host_arbiter.sv | 134 +++++++++++++
 tb/tb_sgd_wr_host_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sgd_wr_host_arbiter_if.sv
// One private copy of the host write channel: a command (start/addr/length) plus a data
// beat stream with almost_full back-pressure flowing back toward the producer.
interface sgd_wr_host_arbiter_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 32
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  length;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  almost_full;

  modport master (output start, addr, length, data, valid, input almost_full);
  modport slave  (input start, addr, length, data, valid, output almost_full);
endinterface

// File: rtl/sgd_wr_host_arbiter.sv
// Packet-granular round-robin arbiter sharing one host write channel between the model
// writeback (p0) and the auxiliary writeback (p1); one whole packet is granted at a time.
module sgd_wr_host_arbiter #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  sgd_wr_host_arbiter_if.slave  p0,
  sgd_wr_host_arbiter_if.slave  p1,
  sgd_wr_host_arbiter_if.master host,
  output logic [1:0]            grant,
  output logic [3:0]            err_flags,
  output logic [31:0]           pkt_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM, DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            start_v, valid_v, slot_full, take, accept, start_drop, beat_drop;
  logic [ADDR_WIDTH-1:0] start_addr [2];
  logic [ADDR_WIDTH-1:0] slot_addr  [2];
  logic [LEN_WIDTH-1:0]  start_len  [2];
  logic [LEN_WIDTH-1:0]  slot_len   [2];
  logic                  pick, issue, last_grant, out_valid_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [LEN_WIDTH-1:0]  out_len_q, beats_q, beat_cnt_q, beats_d;
  logic [LEN_WIDTH:0]    len_round;
  logic [DATA_WIDTH-1:0] out_data_q;

  assign start_v       = {p1.start, p0.start};
  assign valid_v       = {p1.valid, p0.valid};
  assign start_addr[0] = p0.addr;
  assign start_addr[1] = p1.addr;
  assign start_len[0]  = p0.length;
  assign start_len[1]  = p1.length;

  assign accept     = (state_q == STREAM) ? (valid_v & grant) : 2'b00;
  assign beat_drop  = valid_v & ~grant;
  assign start_drop = start_v & slot_full & ~take;

  // Extra top bit keeps the round-up from overflowing near the maximum length.
  assign len_round = {1'b0, slot_len[pick]} + (LEN_WIDTH+1)'(63);
  assign beats_d   = LEN_WIDTH'(len_round >> 6);

  assign p0.almost_full = host.almost_full | ~((state_q == STREAM) & grant[0]);
  assign p1.almost_full = host.almost_full | ~((state_q == STREAM) & grant[1]);

  assign host.start  = (state_q == ISSUE);
  assign host.addr   = out_addr_q;
  assign host.length = out_len_q;
  assign host.data   = out_data_q;
  assign host.valid  = out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Winner selection: a lone requester wins, a tie goes to the port that was not served last.
  always_comb begin
    state_d = state_q;
    pick    = 1'b0;
    take    = 2'b00;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|slot_full) begin
          pick = (slot_full == 2'b11) ? ~last_grant : slot_full[1];
          take = pick ? 2'b10 : 2'b01;
          if (slot_len[pick] != '0) begin
            issue   = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE:   state_d = STREAM;
      STREAM:  if ((|accept) && (beat_cnt_q == beats_q - LEN_WIDTH'(1))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_full   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        slot_addr[i] <= '0;
        slot_len[i]  <= '0;
      end
      grant       <= 2'b00;
      last_grant  <= 1'b1;
      err_flags   <= 4'b0000;
      pkt_count   <= 32'd0;
      out_addr_q  <= '0;
      out_len_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      beats_q     <= '0;
      beat_cnt_q  <= '0;
    end else begin
      // A slot being consumed this cycle is free again for a same-cycle start.
      for (int i = 0; i < 2; i++) begin
        if (take[i] || !slot_full[i]) begin
          slot_full[i] <= start_v[i];
          if (start_v[i]) begin
            slot_addr[i] <= start_addr[i];
            slot_len[i]  <= start_len[i];
          end
        end
      end
      err_flags   <= err_flags | {beat_drop, start_drop};
      out_valid_q <= |accept;
      if (|accept) begin
        out_data_q <= accept[1] ? p1.data : p0.data;
        beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
      end
      if (issue) begin
        grant      <= take;
        out_addr_q <= slot_addr[pick];
        out_len_q  <= slot_len[pick];
        beats_q    <= beats_d;
        beat_cnt_q <= '0;
      end
      if (state_q == DONE) begin
        pkt_count  <= pkt_count + 32'd1;
        last_grant <= grant[1];
        grant      <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_sgd_wr_host_arbiter.sv
// Directed bench for sgd_wr_host_arbiter: single packets, ties, round-robin order,
// back-pressure, error flags, zero/one-byte lengths and reset in the middle of a packet.
module tb_sgd_wr_host_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  grant;
  logic [3:0]  err_flags;
  logic [31:0] pkt_count;
  int          checks;
  int          passes;

  sgd_wr_host_arbiter_if p0_if ();
  sgd_wr_host_arbiter_if p1_if ();
  sgd_wr_host_arbiter_if host_if ();

  sgd_wr_host_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .p0        (p0_if),
    .p1        (p1_if),
    .host      (host_if),
    .grant     (grant),
    .err_flags (err_flags),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] beat_word(input logic [7:0] tag, input int idx);
    logic [31:0] w;
    w = {tag, 8'(idx), 16'hBEEF};
    return {16{w}};
  endfunction

  task automatic check_output(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    checks++;
    assert (observed === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  task automatic set_start(input int port, input logic s, input logic [63:0] addr, input logic [31:0] len);
    if (port == 0) begin
      p0_if.start = s; p0_if.addr = addr; p0_if.length = len;
    end else begin
      p1_if.start = s; p1_if.addr = addr; p1_if.length = len;
    end
  endtask

  task automatic drive_beat(input int port, input logic v, input logic [511:0] d);
    if (port == 0) begin
      p0_if.valid = v; p0_if.data = d;
    end else begin
      p1_if.valid = v; p1_if.data = d;
    end
  endtask

  // Pulse one start command on a port for a single cycle.
  task automatic apply_stimulus(input int port, input logic [63:0] addr, input logic [31:0] len);
    set_start(port, 1'b1, addr, len);
    tick();
    set_start(port, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    set_start(0, 1'b0, '0, '0);
    set_start(1, 1'b0, '0, '0);
    drive_beat(0, 1'b0, '0);
    drive_beat(1, 1'b0, '0);
    host_if.almost_full = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Starts in the IDLE cycle where the winner's slot is full; ends in the IDLE after DONE.
  task automatic run_packet(input int port, input logic [63:0] addr, input logic [31:0] len,
                            input int nbeats, input logic [7:0] tag);
    tick();
    set_start(0, 1'b0, '0, '0);
    set_start(1, 1'b0, '0, '0);
    check_output("issue_start", host_if.start, 1);
    check_output("issue_addr", host_if.addr, addr);
    check_output("issue_len", host_if.length, len);
    check_output("issue_grant", grant, (port == 0) ? 2'b01 : 2'b10);
    tick();
    check_output("start_pulse_end", host_if.start, 0);
    check_output("own_af", (port == 0) ? p0_if.almost_full : p1_if.almost_full, 0);
    for (int i = 0; i < nbeats; i++) begin
      check_output("other_af", (port == 0) ? p1_if.almost_full : p0_if.almost_full, 1);
      drive_beat(port, 1'b1, beat_word(tag, i));
      tick();
      check_output("beat_valid", host_if.valid, 1);
      check_output("beat_data", host_if.data, beat_word(tag, i));
    end
    drive_beat(port, 1'b0, '0);
    tick();
    check_output("post_valid", host_if.valid, 0);
    check_output("post_grant", grant, 2'b00);
  endtask

  initial begin
    clk    = 1'b0;
    checks = 0;
    passes = 0;
    do_reset();

    $display("[TB] reset state");
    check_output("rst_grant", grant, 2'b00);
    check_output("rst_err", err_flags, 0);
    check_output("rst_pkt", pkt_count, 0);
    check_output("rst_start", host_if.start, 0);
    check_output("rst_valid", host_if.valid, 0);
    check_output("rst_addr", host_if.addr, 0);
    check_output("rst_len", host_if.length, 0);
    check_output("rst_p0_af", p0_if.almost_full, 1);

    $display("[TB] single p0 packet");
    apply_stimulus(0, 64'h1000, 32'd256);
    check_output("early_start", host_if.start, 0);
    run_packet(0, 64'h1000, 32'd256, 4, 8'h01);
    check_output("single_pkt", pkt_count, 1);

    $display("[TB] simultaneous starts");
    do_reset();
    set_start(0, 1'b1, 64'h4000, 32'd128);
    set_start(1, 1'b1, 64'h5000, 32'd128);
    tick();
    set_start(0, 1'b0, '0, '0);
    set_start(1, 1'b0, '0, '0);
    run_packet(0, 64'h4000, 32'd128, 2, 8'h20);
    check_output("tie_pkt1", pkt_count, 1);
    run_packet(1, 64'h5000, 32'd128, 2, 8'h21);
    check_output("tie_pkt2", pkt_count, 2);

    $display("[TB] round robin");
    do_reset();
    set_start(0, 1'b1, 64'hA000, 32'd64);
    set_start(1, 1'b1, 64'hB000, 32'd64);
    tick();
    set_start(1, 1'b0, '0, '0);
    set_start(0, 1'b1, 64'hC000, 32'd64);
    run_packet(0, 64'hA000, 32'd64, 1, 8'h10);
    run_packet(1, 64'hB000, 32'd64, 1, 8'h11);
    run_packet(0, 64'hC000, 32'd64, 1, 8'h12);
    check_output("rr_pkt", pkt_count, 3);
    check_output("rr_err", err_flags, 0);

    $display("[TB] back-pressure");
    do_reset();
    apply_stimulus(1, 64'h6000, 32'd256);
    tick();
    tick();
    drive_beat(1, 1'b1, beat_word(8'h30, 0));
    tick();
    check_output("bp_b0", host_if.data, beat_word(8'h30, 0));
    for (int k = 0; k < 10; k++) begin
      host_if.almost_full = 1'b1;
      drive_beat(1, (k == 0), beat_word(8'h30, 1));
      #1;
      check_output("bp_p1_af", p1_if.almost_full, 1);
      check_output("bp_p0_af", p0_if.almost_full, 1);
      tick();
      check_output("bp_valid", host_if.valid, (k == 0) ? 1 : 0);
    end
    check_output("bp_b1", host_if.data, beat_word(8'h30, 1));
    host_if.almost_full = 1'b0;
    drive_beat(1, 1'b0, '0);
    #1;
    check_output("bp_release_af", p1_if.almost_full, 0);
    for (int i = 2; i < 4; i++) begin
      drive_beat(1, 1'b1, beat_word(8'h30, i));
      tick();
      check_output("bp_tail", host_if.data, beat_word(8'h30, i));
    end
    drive_beat(1, 1'b0, '0);
    tick();
    check_output("bp_post_valid", host_if.valid, 0);
    check_output("bp_pkt", pkt_count, 1);

    $display("[TB] error flags");
    do_reset();
    drive_beat(1, 1'b1, beat_word(8'h40, 0));
    tick();
    drive_beat(1, 1'b0, '0);
    check_output("err_beat_flag", err_flags, 4'b1000);
    check_output("err_beat_valid", host_if.valid, 0);
    apply_stimulus(1, 64'h7000, 32'd64);
    tick();
    apply_stimulus(0, 64'h2000, 32'd64);
    apply_stimulus(0, 64'h3000, 32'd64);
    check_output("err_start_flag", err_flags, 4'b1001);
    drive_beat(1, 1'b1, beat_word(8'h41, 0));
    tick();
    drive_beat(1, 1'b0, '0);
    check_output("err_p1_beat", host_if.data, beat_word(8'h41, 0));
    tick();
    run_packet(0, 64'h2000, 32'd64, 1, 8'h42);
    tick();
    tick();
    check_output("err_no_third", host_if.start, 0);
    check_output("err_pkt", pkt_count, 2);

    $display("[TB] edge lengths");
    apply_stimulus(0, 64'h8000, 32'd1);
    run_packet(0, 64'h8000, 32'd1, 1, 8'h50);
    check_output("len1_pkt", pkt_count, 3);
    apply_stimulus(0, 64'h9000, 32'd0);
    tick();
    check_output("len0_start", host_if.start, 0);
    check_output("len0_grant", grant, 2'b00);
    tick();
    check_output("len0_start2", host_if.start, 0);
    check_output("len0_pkt", pkt_count, 3);
    check_output("len0_addr_held", host_if.addr, 64'h8000);

    $display("[TB] reset mid-stream");
    apply_stimulus(0, 64'hD000, 32'd256);
    tick();
    tick();
    drive_beat(0, 1'b1, beat_word(8'h60, 0));
    tick();
    drive_beat(0, 1'b0, '0);
    check_output("mid_valid", host_if.valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("mid_rst_valid", host_if.valid, 0);
    check_output("mid_rst_data", host_if.data, 0);
    check_output("mid_rst_addr", host_if.addr, 0);
    check_output("mid_rst_len", host_if.length, 0);
    check_output("mid_rst_grant", grant, 2'b00);
    check_output("mid_rst_err", err_flags, 0);
    check_output("mid_rst_pkt", pkt_count, 0);
    check_output("mid_rst_p0_af", p0_if.almost_full, 1);
    tick();
    tick();
    check_output("mid_rst_no_issue", host_if.start, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
